// File: rtl/mux8_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester-side and consumer-side stream bundle of the round-robin mux arbiter.
interface mux8_rr_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    import mux8_arb_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;
    logic [SEL_W-1:0]        sel;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, sel, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, sel, busy
    );

endinterface

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request searching circularly from ptr.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               found;

    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> ptr);
    assign any     = |req;

    // Bit k of the rotated vector is requester ptr+k (mod 8).
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                idx   = ptr + SEL_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one DATA_W-wide 8:1 stream mux among 8 requesters,
// holding the grant for a whole packet when LOCK_PKT is set.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          LOCK_PKT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  sel_q;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;

    logic              busy_c;
    logic              out_valid_c;
    logic              out_last_c;
    logic [DATA_W-1:0] out_data_c;
    logic [N_REQ-1:0]  req_ready_c;
    logic              beat_c;
    logic              release_c;

    rr_pick8 u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign busy_c      = (state == BUSY);
    assign out_valid_c = busy_c & bus.req_valid[sel_q];
    assign out_last_c  = out_valid_c & bus.req_last[sel_q];
    assign beat_c      = out_valid_c & bus.out_ready;
    assign release_c   = beat_c & (out_last_c | ~LOCK_PKT);

    // Steering only while a grant is held, so everything reads 0 in reset/IDLE.
    always_comb begin
        out_data_c  = '0;
        req_ready_c = '0;
        if (busy_c) begin
            out_data_c         = bus.req_data[int'(sel_q)*DATA_W +: DATA_W];
            req_ready_c[sel_q] = bus.out_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_c) begin
                        ptr   <= sel_q + SEL_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;
    assign bus.req_ready = req_ready_c;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus a randomized run
// against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mux8_rr_arbiter_if #(.DATA_W(8)) bus ();

    mux8_rr_arbiter #(.DATA_W(8), .LOCK_PKT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    // Reference winner: first valid requester at ptr, ptr+1, ... modulo 8; -1 if none.
    function automatic int model_pick(input logic [7:0] valid, input int p);
        for (int k = 0; k < 8; k++)
            if (valid[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic test_reset();
        idle_inputs();
        bus.req_valid = 8'hFF;
        bus.req_last  = 8'hFF;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b req_ready=%h sel=%0d busy=%b, required 0/00/0/0",
                     bus.out_valid, bus.req_ready, bus.sel, bus.busy);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_no_beat: busy=%b out_valid=%b, required 0/0", bus.busy, bus.out_valid);
        end
        step();
        tests++;
        if (bus.busy !== 1'b1 || bus.sel !== 3'd0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: busy=%b sel=%0d out_valid=%b, required 1/0/1",
                     bus.busy, bus.sel, bus.out_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req_valid = 8'hFF;
        bus.req_last  = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rotation_bubble[%0d]: busy=%b out_valid=%b, required 0/0", i, bus.busy, bus.out_valid);
            end
            step();
            tests++;
            if (bus.busy !== 1'b1 || bus.sel !== 3'(i % 8) || bus.out_last !== 1'b1 ||
                bus.req_ready !== 8'(1 << (i % 8))) begin
                fails++;
                $display("FAIL rotation_grant[%0d]: sel=%0d busy=%b last=%b ready=%h, required sel=%0d",
                         i, bus.sel, bus.busy, bus.out_last, bus.req_ready, i % 8);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_last  = 8'hFF;
        bus.out_ready = 1'b1;
        bus.req_valid = 8'h20;
        step();
        step();
        bus.req_valid = 8'h84;
        set_data(7, 8'hA7);
        set_data(2, 8'hA2);
        step();
        tests++;
        if (bus.sel !== 3'd7 || bus.out_data !== 8'hA7 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_first: sel=%0d data=%h valid=%b, required 7/a7/1", bus.sel, bus.out_data, bus.out_valid);
        end
        step();
        step();
        tests++;
        if (bus.sel !== 3'd2 || bus.out_data !== 8'hA2 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL wrap_second: sel=%0d data=%h busy=%b, required 2/a2/1", bus.sel, bus.out_data, bus.busy);
        end
    endtask

    task automatic test_packet_lock();
        do_reset();
        bus.req_valid = 8'h18;
        bus.out_ready = 1'b1;
        set_data(4, 8'h44);
        set_data(3, 8'h30);
        step();
        for (int b = 0; b < 4; b++) begin
            set_data(3, 8'(8'h30 + b));
            bus.req_last[3] = (b == 3);
            #1;
            tests++;
            if (bus.sel !== 3'd3 || bus.out_data !== 8'(8'h30 + b) || bus.out_last !== (b == 3) ||
                bus.req_ready !== 8'h08 || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL lock_beat[%0d]: sel=%0d data=%h last=%b ready=%h, required 3/%h/%b/08",
                         b, bus.sel, bus.out_data, bus.out_last, bus.req_ready, 8'(8'h30 + b), b == 3);
            end
            step();
        end
        bus.req_last = 8'h00;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL lock_release: busy=%b, required 0", bus.busy);
        end
        step();
        tests++;
        if (bus.sel !== 3'd4 || bus.out_data !== 8'h44 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL lock_next_grant: sel=%0d data=%h, required 4/44", bus.sel, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req_valid = 8'h02;
        bus.out_ready = 1'b1;
        set_data(1, 8'h11);
        step();
        step();
        bus.out_ready = 1'b0;
        set_data(1, 8'h12);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12 || bus.req_ready !== 8'h00 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h ready=%h busy=%b, required 1/12/00/1",
                         c, bus.out_valid, bus.out_data, bus.req_ready, bus.busy);
            end
            step();
        end
        bus.out_ready = 1'b1;
        bus.req_valid = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.sel !== 3'd1 || bus.out_last !== 1'b0) begin
                fails++;
                $display("FAIL owner_drop[%0d]: valid=%b busy=%b sel=%0d last=%b, required 0/1/1/0",
                         c, bus.out_valid, bus.busy, bus.sel, bus.out_last);
            end
            step();
        end
        bus.req_valid = 8'h02;
        bus.req_last  = 8'h02;
        set_data(1, 8'h13);
        step();
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 8'h04;
        bus.req_last  = 8'h04;
        step();
        step();
        bus.req_valid = 8'h20;
        bus.req_last  = 8'h00;
        set_data(5, 8'h55);
        step();
        step();
        tests++;
        if (bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL areset_setup: sel=%0d busy=%b, required 5/1", bus.sel, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.req_ready !== 8'h00 || bus.sel !== 3'd0 ||
            bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
            fails++;
            $display("FAIL areset_outputs: valid=%b ready=%h sel=%0d busy=%b data=%h, required all 0",
                     bus.out_valid, bus.req_ready, bus.sel, bus.busy, bus.out_data);
        end
        step();
        rst = 1'b0;
        bus.req_valid = 8'h21;
        bus.req_last  = 8'h21;
        step();
        tests++;
        if (bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL areset_ptr: sel=%0d busy=%b, required 0/1", bus.sel, bus.busy);
        end
    endtask

    task automatic test_random();
        bit         m_busy;
        int         m_sel;
        int         m_ptr;
        logic [7:0] rv;
        logic [7:0] rl;
        logic       ordy;
        logic [7:0] exp_ready;
        int         w;
        do_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                rv[i] = ($urandom_range(0, 3) != 0);
                rl[i] = ($urandom_range(0, 2) == 0);
                set_data(i, 8'($urandom));
            end
            ordy = ($urandom_range(0, 3) != 0);
            bus.req_valid = rv;
            bus.req_last  = rl;
            bus.out_ready = ordy;
            #1;
            exp_ready = m_busy ? 8'({7'd0, ordy} << m_sel) : 8'h00;
            tests++;
            if (bus.busy !== m_busy || bus.req_ready !== exp_ready ||
                bus.out_valid !== (m_busy && rv[m_sel]) ||
                bus.out_last !== (m_busy && rv[m_sel] && rl[m_sel]) ||
                (m_busy && bus.sel !== 3'(m_sel)) ||
                (m_busy && rv[m_sel] && bus.out_data !== bus.req_data[m_sel*8 +: 8])) begin
                fails++;
                $display("FAIL random[%0d]: busy=%b sel=%0d valid=%b last=%b ready=%h, required busy=%b sel=%0d ready=%h",
                         c, bus.busy, bus.sel, bus.out_valid, bus.out_last, bus.req_ready, m_busy, m_sel, exp_ready);
            end
            if (!m_busy) begin
                w = model_pick(rv, m_ptr);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_sel  = w;
                end
            end else if (rv[m_sel] && ordy && rl[m_sel]) begin
                m_ptr  = (m_sel + 1) % 8;
                m_busy = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_rotation();
        test_wrap();
        test_packet_lock();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
